// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through character buffer with
// sticky overflow, level-threshold and idle-timeout interrupts.
module uart_rx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          clr,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  input  logic          wr_error,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_error,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  input  logic [AW:0]   thresh,
  output logic          thresh_irq,
  input  logic [15:0]   timeout_cfg,
  output logic          timeout_irq
);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [15:0]   idle_cnt;
  logic          push;
  logic          pop;
  logic          idle_clr;
  logic          ovf_set;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop      = rd_en & ~empty;
  assign push     = wr_valid & (~full | pop);
  assign ovf_set  = wr_valid & full & ~pop;
  assign idle_clr = push | pop | empty;

  assign rd_data    = empty ? 8'h00 : mem[rptr][7:0];
  assign rd_error   = empty ? 1'b0  : mem[rptr][8];
  assign thresh_irq = (thresh != '0) && (level >= thresh);

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wptr] <= {wr_error, wr_data};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        push & ~pop: level <= level + 1'b1;
        pop & ~push: level <= level - 1'b1;
        default:     level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idle_cnt    <= '0;
      timeout_irq <= 1'b0;
    end else if (clr || idle_clr) begin
      idle_cnt    <= '0;
      timeout_irq <= 1'b0;
    end else begin
      if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 1'b1;
      if (timeout_cfg != '0 && idle_cnt == timeout_cfg) begin
        timeout_irq <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based
// reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_error = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_error;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   thresh = '0;
  logic          thresh_irq;
  logic [15:0]   timeout_cfg = '0;
  logic          timeout_irq;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .clr(clr),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_error(wr_error), .rd_en(rd_en),
    .rd_data(rd_data), .rd_error(rd_error),
    .empty(empty), .full(full), .level(level),
    .overflow(overflow), .ovf_clr(ovf_clr),
    .thresh(thresh), .thresh_irq(thresh_irq),
    .timeout_cfg(timeout_cfg),
    .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q[$];
  bit         m_ovf;
  bit         m_irq;
  int         m_idle;
  logic [7:0] last_rd;
  logic       last_irq;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_irq  = 0;
    m_idle = 0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("level", level, n);
    chk("rd_data", rd_data, n ? q[0][7:0] : 8'h00);
    chk("rd_error", rd_error, n ? q[0][8] : 1'b0);
    chk("overflow", overflow, m_ovf);
    chk("thresh_irq", thresh_irq,
        thresh != 0 && n >= int'(thresh));
    chk("timeout_irq", timeout_irq, m_irq);
  endtask

  // One clock: drive, check pre-edge state, then advance the model.
  task automatic step(input logic w, input logic [7:0] d,
                      input logic e, input logic r,
                      input logic c, input logic oc);
    bit p, wa, idle_clr;
    int n;
    @(negedge clk);
    wr_valid = w; wr_data = d; wr_error = e;
    rd_en = r; clr = c; ovf_clr = oc;
    #1;
    check_all();
    last_rd  = rd_data;
    last_irq = timeout_irq;
    @(posedge clk);
    n = q.size();
    if (c) begin
      model_reset();
    end else begin
      p  = r && n > 0;
      wa = w && (n < DEPTH || p);
      idle_clr = p || wa || n == 0;
      if (idle_clr) begin
        m_irq  = 0;
        m_idle = 0;
      end else begin
        if (timeout_cfg != 0 && m_idle == int'(timeout_cfg))
          m_irq = 1;
        if (m_idle < 65535) m_idle++;
      end
      if (w && n == DEPTH && !p) m_ovf = 1;
      else if (oc) m_ovf = 0;
      if (p) void'(q.pop_front());
      if (wa) q.push_back({e, d});
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] d, input logic e);
    step(1, d, e, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 0, 1, 0, 0);
  endtask

  initial begin
    int seen;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    arst_n = 1'b1;

    // Two characters, then one pop.
    wr(8'h41, 0);
    wr(8'h42, 1);
    idle(1);
    chk("t1_level", level, 2);
    chk("t1_head", rd_data, 8'h41);
    step(0, 8'h00, 0, 1, 0, 0);
    idle(1);
    chk("t1_pop_data", rd_data, 8'h42);
    chk("t1_pop_err", rd_error, 1'b1);
    chk("t1_pop_level", level, 1);
    drain();

    // Fill, overflow, then simultaneous write+pop while full.
    for (int i = 0; i < 16; i++) wr(8'(i), 0);
    wr(8'hFF, 0);
    idle(1);
    chk("t2_full", full, 1'b1);
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_level", level, 16);
    step(0, 8'h00, 0, 0, 0, 1);
    step(1, 8'hAA, 0, 1, 0, 0);
    idle(1);
    chk("t3_level", level, 16);
    chk("t3_ovf", overflow, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step(0, 8'h00, 0, 1, 0, 0);
      chk("t3_drain", last_rd, 8'(i));
    end
    step(0, 8'h00, 0, 1, 0, 0);
    chk("t3_last", last_rd, 8'hAA);
    idle(1);
    chk("t3_empty", empty, 1'b1);

    // Threshold interrupt.
    thresh = 4;
    for (int i = 0; i < 4; i++) wr(8'h30 + 8'(i), 0);
    idle(1);
    chk("t4_irq_on", thresh_irq, 1'b1);
    step(0, 8'h00, 0, 1, 0, 0);
    idle(1);
    chk("t4_irq_off", thresh_irq, 1'b0);
    thresh = 0;
    for (int i = 0; i < 6; i++) wr(8'h50, 0);
    chk("t4_disabled", thresh_irq, 1'b0);
    drain();

    // Idle timeout.
    timeout_cfg = 16'd10;
    wr(8'h77, 0);
    seen = 0;
    for (int i = 0; i < 30 && !last_irq; i++) begin
      idle(1);
      seen = i + 1;
    end
    chk("t5_irq_seen", last_irq, 1'b1);
    chk("t5_irq_cycle", seen, 12);
    step(0, 8'h00, 0, 1, 0, 0);
    idle(1);
    chk("t5_irq_clr", timeout_irq, 1'b0);
    chk("t5_empty", empty, 1'b1);
    timeout_cfg = 16'd0;
    wr(8'h78, 0);
    idle(1000);
    chk("t5_disabled", timeout_irq, 1'b0);
    drain();

    // clr beats a coincident write and ovf_clr.
    for (int i = 0; i < 17; i++) wr(8'h60 + 8'(i), 0);
    idle(1);
    chk("t6_ovf", overflow, 1'b1);
    step(1, 8'h99, 0, 0, 1, 1);
    idle(1);
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_ovf_clr", overflow, 1'b0);
    chk("t6_rd", rd_data, 8'h00);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i), 1);
    @(negedge clk);
    wr_valid = 1'b1;
    @(posedge clk);
    #2 arst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    wr_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0)
        thresh = (AW+1)'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 99) == 0)
        timeout_cfg = 16'($urandom_range(0, 20));
      step($urandom_range(0, 99) < 55, 8'($urandom),
           1'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) idle($urandom_range(5, 30));
    end
    @(negedge clk);
    #1;
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
